// File: rtl/cpu_mult_pkg.sv
//------------------------------------------------------------------------------
// Module      : cpu_mult_pkg
// Description : Shared mode/state encodings and operand-sign helpers for the
//               sequential M-stage multiplier.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package cpu_mult_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MULXSS = 2'd1,
    MULXSU = 2'd2,
    MULXUU = 2'd3
  } mult_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_e;

  // The low word is sign-agnostic, so MUL_LO treats both operands as unsigned.
  function automatic logic src1_is_signed(input mult_mode_e mode);
    return (mode == MULXSS) || (mode == MULXSU);
  endfunction

  function automatic logic src2_is_signed(input mult_mode_e mode);
    return (mode == MULXSS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_mult_slice.sv
//------------------------------------------------------------------------------
// Module      : cpu_mult_slice
// Description : Combinational WIDTH x PART_W unsigned multiply (one DSP slice).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cpu_mult_slice #(
  parameter int WIDTH  = 32,
  parameter int PART_W = 16
) (
  input  logic [WIDTH-1:0]        a,
  input  logic [PART_W-1:0]       b,
  output logic [WIDTH+PART_W-1:0] p
);

  assign p = {{PART_W{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

`default_nettype wire

// File: rtl/cpu_mult_seq.sv
//------------------------------------------------------------------------------
// Module      : cpu_mult_seq
// Description : Sequential signed/unsigned multiplier, one PART_W slice of src2
//               per cycle, valid/ready on both sides.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cpu_mult_seq
  import cpu_mult_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PART_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  localparam int NUM_PARTS = WIDTH / PART_W;
  localparam int CNT_W     = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
  localparam int ACC_W     = 2 * WIDTH;

  mult_state_e        state_q, state_d;
  mult_mode_e         mode_q, mode_d;
  logic [WIDTH-1:0]   src1_q, src1_d;
  logic [WIDTH-1:0]   src2_q, src2_d;
  logic               neg_q, neg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;

  mult_mode_e              w_mode;
  logic                    w_neg1, w_neg2;
  logic [WIDTH-1:0]        w_abs1, w_abs2;
  logic [WIDTH+PART_W-1:0] w_pp;
  logic [ACC_W-1:0]        w_pp_ext;
  logic [31:0]             w_shamt;
  logic [ACC_W-1:0]        w_acc_fix;

  cpu_mult_slice #(
    .WIDTH  (WIDTH),
    .PART_W (PART_W)
  ) u_slice (
    .a (src1_q),
    .b (src2_q[PART_W-1:0]),
    .p (w_pp)
  );

  always_comb begin
    w_mode    = mult_mode_e'(in_mode);
    w_neg1    = src1_is_signed(w_mode) & in_src1[WIDTH-1];
    w_neg2    = src2_is_signed(w_mode) & in_src2[WIDTH-1];
    w_abs1    = w_neg1 ? -in_src1 : in_src1;
    w_abs2    = w_neg2 ? -in_src2 : in_src2;
    w_pp_ext  = '0;
    w_pp_ext[WIDTH+PART_W-1:0] = w_pp;
    w_shamt   = 32'(cnt_q) * 32'(PART_W);
    w_acc_fix = neg_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = w_mode;
          src1_d  = w_abs1;
          src2_d  = w_abs2;
          neg_d   = w_neg1 ^ w_neg2;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // src2 shifts down so the slice multiplier always sees the next slice.
        acc_d  = acc_q + (w_pp_ext << w_shamt);
        src2_d = src2_q >> PART_W;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_PARTS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        acc_d    = w_acc_fix;
        result_d = (mode_q == MUL_LO) ? w_acc_fix[WIDTH-1:0] : w_acc_fix[ACC_W-1:WIDTH];
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MUL_LO;
      src1_q   <= '0;
      src2_q   <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mult_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_cpu_mult_seq
// Description : Directed self-checking bench for cpu_mult_seq (32/16 and 16/8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_mult_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, sel;
  logic [1:0]  mode;
  logic [31:0] src1, src2;

  logic        iv32, iv16;
  logic        ir32, ov32, ir16, ov16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic        cur_ir, cur_ov;
  logic [31:0] cur_res;

  assign iv32    = in_valid & ~sel;
  assign iv16    = in_valid & sel;
  assign cur_ir  = sel ? ir16 : ir32;
  assign cur_ov  = sel ? ov16 : ov32;
  assign cur_res = sel ? {16'h0000, res16} : res32;

  cpu_mult_seq dut32 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (iv32),
    .in_ready   (ir32),
    .in_src1    (src1),
    .in_src2    (src2),
    .in_mode    (mode),
    .out_valid  (ov32),
    .out_ready  (out_ready),
    .out_result (res32)
  );

  cpu_mult_seq #(
    .WIDTH  (16),
    .PART_W (8)
  ) dut16 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (iv16),
    .in_ready   (ir16),
    .in_src1    (src1[15:0]),
    .in_src2    (src2[15:0]),
    .in_mode    (mode),
    .out_valid  (ov16),
    .out_ready  (out_ready),
    .out_result (res16)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One transaction: w16 selects the 16-bit instance, hold = DONE backpressure
  // cycles, junk = keep a bogus request on in_valid while the unit is busy.
  task automatic run_op(input bit w16, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold,
                        input bit junk, input string tag);
    int lat;
    bit busy_ok;
    int stray;
    @(negedge clk);
    sel = w16; mode = m; src1 = a; src2 = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    chk({tag, ".in_ready_idle"}, 32'(cur_ir), 32'd1);
    @(posedge clk);
    lat = 0;
    busy_ok = 1'b1;
    for (;;) begin
      @(negedge clk);
      if (junk) begin
        in_valid = 1'b1; src1 = 32'h0000DEAD; src2 = 32'h0000BEEF; mode = 2'd3;
      end else begin
        in_valid = 1'b0;
      end
      if (cur_ir) busy_ok = 1'b0;
      if (cur_ov || lat >= 20) break;
      @(posedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'd3);
    chk({tag, ".in_ready_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, ".result"}, cur_res, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(cur_ov), 32'd1);
      chk({tag, ".hold_result"}, cur_res, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".valid_drop"}, 32'(cur_ov), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(cur_ir), 32'd1);
    if (junk) begin
      stray = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (cur_ov) stray++;
      end
      chk({tag, ".no_junk_op"}, 32'(stray), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    mode = 2'd0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    chk("rst.ir32", 32'(ir32), 32'd1);
    chk("rst.ov32", 32'(ov32), 32'd0);
    chk("rst.res32", res32, 32'd0);
    chk("rst.ir16", 32'(ir16), 32'd1);
    chk("rst.ov16", 32'(ov16), 32'd0);
    chk("rst.res16", {16'h0, res16}, 32'd0);
    reset = 1'b0;

    run_op(1'b0, 2'd0, 32'd3, 32'd5, 32'h0000000F, 0, 1'b0, "mul_3x5");
    run_op(1'b0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1'b0, "xuu_ones");
    run_op(1'b0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1'b0, "xss_ones");
    run_op(1'b0, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, "xsu_ones");
    run_op(1'b0, 2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1'b0, "xss_min");
    run_op(1'b0, 2'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 0, 1'b0, "mul_m1x7");
    run_op(1'b0, 2'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 0, 1'b0, "xss_m2x3");
    run_op(1'b0, 2'd1, 32'd0, 32'h80000000, 32'h00000000, 0, 1'b0, "xss_zero");
    run_op(1'b0, 2'd3, 32'h00010000, 32'h00030000, 32'h00000003, 5, 1'b1, "backpressure");

    // Abort during the second CALC cycle.
    @(negedge clk);
    sel = 1'b0; mode = 2'd0; src1 = 32'd9; src2 = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.in_ready", 32'(ir32), 32'd1);
    chk("abort.out_valid", 32'(ov32), 32'd0);
    chk("abort.result", res32, 32'd0);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ov32) stray++;
    end
    chk("abort.no_emit", 32'(stray), 32'd0);
    run_op(1'b0, 2'd0, 32'd6, 32'd7, 32'd42, 0, 1'b0, "after_abort");

    run_op(1'b1, 2'd0, 32'h00001234, 32'h00005678, 32'h00000060, 0, 1'b0, "w16_mul");
    run_op(1'b1, 2'd3, 32'h00001234, 32'h00005678, 32'h00000626, 0, 1'b0, "w16_xuu");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
